// File: rtl/gray_threshold_stage.sv
// gray_threshold_stage
//
// Purpose:
//   Converts 32-bit 0x00RRGGBB pixel beats into 8-bit luma
//   (Y = (77*R + 150*G + 29*B) >> 8) and emits 0x00YYYYYY beats. Optionally
//   binarises the luma against a threshold, with an optional inversion.
//   Threshold configuration is captured at the start of each packet and
//   applies to the whole packet. Beats per packet and completed packets are
//   counted, and a sticky flag reports packets whose length differs from
//   EXPECTED_LEN.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_valid/s_ready      input beat handshake
//   s_data/s_strb/s_last input pixel {8'h00,R,G,B}, byte strobes, end of packet
//   m_valid/m_ready      output beat handshake
//   m_data/m_strb/m_last output {8'h00,Y,Y,Y}, delayed strobes / last
//   cfg_thresh_en        enable binarisation
//   cfg_thresh           threshold (Y >= thresh -> 8'hFF)
//   cfg_invert           invert the binarised byte
//   pix_count            beat count of the last completed packet
//   frame_count          completed packets (wraps)
//   len_error            sticky length-mismatch flag (cleared by reset only)
//
// Optional feature (macro GRAY_STATS_EN):
//   luma_min / luma_max  min/max pre-threshold luma of the last completed
//                        output packet.

module gray_threshold_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int EXPECTED_LEN = 0,
    parameter int CNT_WIDTH    = 24
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic [DATA_WIDTH/8-1:0] s_strb,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [DATA_WIDTH/8-1:0] m_strb,
    output logic                    m_last,
    input  logic                    cfg_thresh_en,
    input  logic [7:0]              cfg_thresh,
    input  logic                    cfg_invert,
    output logic [CNT_WIDTH-1:0]    pix_count,
    output logic [CNT_WIDTH-1:0]    frame_count,
    output logic                    len_error
`ifdef GRAY_STATS_EN
    ,
    output logic [7:0]              luma_min,
    output logic [7:0]              luma_max
`endif
);

    // Pipeline control
    logic v1;
    logic adv1;
    logic adv2;
    logic s_fire;

    assign adv2    = !m_valid || m_ready;
    assign adv1    = !v1 || adv2;
    assign s_ready = adv1;
    assign s_fire  = s_valid && s_ready;

    // Per-packet configuration. The first beat of a packet uses the live
    // cfg inputs (they are being latched on that same edge); later beats
    // use the latched copy.
    logic       sof;
    logic       en_q;
    logic [7:0] thresh_q;
    logic       inv_q;
    logic       en_eff;
    logic [7:0] thresh_eff;
    logic       inv_eff;

    assign en_eff     = sof ? cfg_thresh_en : en_q;
    assign thresh_eff = sof ? cfg_thresh    : thresh_q;
    assign inv_eff    = sof ? cfg_invert    : inv_q;

    // Stage 1 weighted products
    logic [15:0] pr_next;
    logic [15:0] pg_next;
    logic [15:0] pb_next;

    assign pr_next = 16'(s_data[23:16]) * 16'd77;
    assign pg_next = 16'(s_data[15:8])  * 16'd150;
    assign pb_next = 16'(s_data[7:0])   * 16'd29;

    logic [15:0]             pr1;
    logic [15:0]             pg1;
    logic [15:0]             pb1;
    logic [DATA_WIDTH/8-1:0] strb1;
    logic                    last1;
    logic                    en1;
    logic [7:0]              thresh1;
    logic                    inv1;

    // Stage 2 combinational luma and output byte
    logic [16:0] sum;
    logic [7:0]  y;
    logic [7:0]  out_byte;

    assign sum = {1'b0, pr1} + {1'b0, pg1} + {1'b0, pb1};
    assign y   = sum[15:8];

    always_comb begin
        out_byte = y;
        if (en1) begin
            out_byte = ((y >= thresh1) ? 8'hFF : 8'h00) ^ {8{inv1}};
        end
    end

    // Bits that are intentionally dropped: the pad byte of the input pixel
    // and the fractional / carry bits of the weighted sum.
    logic unused_bits;
    assign unused_bits = ^{s_data[DATA_WIDTH-1:24], sum[16], sum[7:0]};

    // Stage 1 register: loads products, sideband and per-beat config on
    // each accepted input beat; the valid follows adv1 so a bubble clears.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1      <= 1'b0;
            pr1     <= '0;
            pg1     <= '0;
            pb1     <= '0;
            strb1   <= '0;
            last1   <= 1'b0;
            en1     <= 1'b0;
            thresh1 <= '0;
            inv1    <= 1'b0;
        end else if (adv1) begin
            v1 <= s_valid;
            if (s_valid) begin
                pr1     <= pr_next;
                pg1     <= pg_next;
                pb1     <= pb_next;
                strb1   <= s_strb;
                last1   <= s_last;
                en1     <= en_eff;
                thresh1 <= thresh_eff;
                inv1    <= inv_eff;
            end
        end
    end

    // Stage 2 register: drives the output stream and holds it while stalled.
    logic [7:0] y2;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_strb  <= '0;
            m_last  <= 1'b0;
            y2      <= '0;
        end else if (adv2) begin
            m_valid <= v1;
            if (v1) begin
                m_data <= {{(DATA_WIDTH-24){1'b0}}, out_byte, out_byte, out_byte};
                m_strb <= strb1;
                m_last <= last1;
                y2     <= y;
            end
        end
    end

    // Start-of-frame tracking and configuration capture
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sof      <= 1'b1;
            en_q     <= 1'b0;
            thresh_q <= '0;
            inv_q    <= 1'b0;
        end else if (s_fire) begin
            sof <= s_last;
            if (sof) begin
                en_q     <= cfg_thresh_en;
                thresh_q <= cfg_thresh;
                inv_q    <= cfg_invert;
            end
        end
    end

    // Packet length counters. run_inc is the saturating beat count including
    // the current beat, used both for the running count and for publishing.
    logic [CNT_WIDTH-1:0] run_cnt;
    logic [CNT_WIDTH-1:0] run_inc;

    assign run_inc = (run_cnt == {CNT_WIDTH{1'b1}}) ? run_cnt : run_cnt + 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_cnt     <= '0;
            pix_count   <= '0;
            frame_count <= '0;
            len_error   <= 1'b0;
        end else if (s_fire) begin
            if (s_last) begin
                run_cnt     <= '0;
                pix_count   <= run_inc;
                frame_count <= frame_count + 1'b1;
                if ((EXPECTED_LEN != 0) && (run_inc != CNT_WIDTH'(EXPECTED_LEN))) begin
                    len_error <= 1'b1;
                end
            end else begin
                run_cnt <= run_inc;
            end
        end
    end

`ifdef GRAY_STATS_EN
    // Running luma statistics over output beats, published at end of packet.
    logic [7:0] run_min;
    logic [7:0] run_max;
    logic [7:0] next_min;
    logic [7:0] next_max;
    logic       m_fire;

    assign m_fire   = m_valid && m_ready;
    assign next_min = (y2 < run_min) ? y2 : run_min;
    assign next_max = (y2 > run_max) ? y2 : run_max;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_min  <= 8'hFF;
            run_max  <= 8'h00;
            luma_min <= 8'hFF;
            luma_max <= 8'h00;
        end else if (m_fire) begin
            if (m_last) begin
                luma_min <= next_min;
                luma_max <= next_max;
                run_min  <= 8'hFF;
                run_max  <= 8'h00;
            end else begin
                run_min <= next_min;
                run_max <= next_max;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_threshold_stage.sv
// Testbench for gray_threshold_stage (instantiated with EXPECTED_LEN = 4).
// Stimulus tasks push hand-computed expected beats into a scoreboard queue;
// an independent monitor pops and compares on every output handshake.

module tb_gray_threshold_stage;

    localparam int CNT_WIDTH = 24;

    logic                 aclk;
    logic                 aresetn;
    logic                 s_valid;
    logic                 s_ready;
    logic [31:0]          s_data;
    logic [3:0]           s_strb;
    logic                 s_last;
    logic                 m_valid;
    logic                 m_ready;
    logic [31:0]          m_data;
    logic [3:0]           m_strb;
    logic                 m_last;
    logic                 cfg_thresh_en;
    logic [7:0]           cfg_thresh;
    logic                 cfg_invert;
    logic [CNT_WIDTH-1:0] pix_count;
    logic [CNT_WIDTH-1:0] frame_count;
    logic                 len_error;

    gray_threshold_stage #(
        .DATA_WIDTH  (32),
        .EXPECTED_LEN(4),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_strb       (s_strb),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_strb       (m_strb),
        .m_last       (m_last),
        .cfg_thresh_en(cfg_thresh_en),
        .cfg_thresh   (cfg_thresh),
        .cfg_invert   (cfg_invert),
        .pix_count    (pix_count),
        .frame_count  (frame_count),
        .len_error    (len_error)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    logic [3:0] strb_pat = 4'h1;

    localparam logic [31:0] WHITE = 32'h00FFFFFF;
    localparam logic [31:0] RED   = 32'h00FF0000;
    localparam logic [31:0] GREEN = 32'h0000FF00;
    localparam logic [31:0] BLUE  = 32'h000000FF;
    localparam logic [31:0] BLACK = 32'h00000000;
    localparam logic [31:0] Y_W   = 32'h00FFFFFF;
    localparam logic [31:0] Y_R   = 32'h004C4C4C;
    localparam logic [31:0] Y_G   = 32'h00959595;
    localparam logic [31:0] Y_B   = 32'h001C1C1C;
    localparam logic [31:0] ZERO  = 32'h00000000;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Drives one beat and waits (bounded) for it to be accepted; the expected
    // output beat is pushed at the moment the handshake is known to occur.
    task automatic applyStimulus(input logic [31:0] data, input logic last,
                                 input logic [31:0] exp_data, input bit lat);
        exp_t e;
        bit   accepted;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        s_strb  = strb_pat;
        accepted = 1'b0;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge aclk);
            if (s_ready) begin
                e.data = exp_data;
                e.strb = strb_pat;
                e.last = last;
                e.cyc  = cyc;
                e.lat  = lat;
                sb.push_back(e);
                accepted = 1'b1;
            end
        end
        if (!accepted) reportTimeout("input_accept");
        @(posedge aclk);
        #1;
        strb_pat = strb_pat + 4'h3;
    endtask

    task automatic idleInput();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drainScoreboard();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (sb.size() != 0) reportTimeout("drain");
    endtask

    // Monitor: compares every output handshake against the scoreboard head.
    always @(negedge aclk) begin
        if (aresetn && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("[TB] FAIL unexpected_beat: got 0x%08h, expected no beat", m_data);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("m_data", m_data, mon_e.data);
                checkOutput("m_strb", {28'h0, m_strb}, {28'h0, mon_e.strb});
                checkOutput("m_last", {31'h0, m_last}, {31'h0, mon_e.last});
                if (mon_e.lat) checkOutput("latency", cyc - mon_e.cyc, 32'd2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] stall_in  [4];
    logic [31:0] stall_exp [4];
    logic [31:0] stall_snap;
    int          idx;
    int          acc;
    bit          took;
    int          wait_n;

    initial begin
        aresetn       = 1'b0;
        s_valid       = 1'b0;
        s_data        = '0;
        s_strb        = '0;
        s_last        = 1'b0;
        m_ready       = 1'b1;
        cfg_thresh_en = 1'b0;
        cfg_thresh    = 8'd0;
        cfg_invert    = 1'b0;
        stall_in[0] = WHITE; stall_in[1] = RED;  stall_in[2] = GREEN; stall_in[3] = BLUE;
        stall_exp[0] = Y_W;  stall_exp[1] = Y_R; stall_exp[2] = Y_G;  stall_exp[3] = Y_B;

        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_m_valid", {31'h0, m_valid}, 32'h0);
        checkOutput("rst_m_data", m_data, 32'h0);
        checkOutput("rst_pix_count", 32'(pix_count), 32'h0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'h0);
        checkOutput("rst_len_error", {31'h0, len_error}, 32'h0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Plain luma, back to back, latency checked
        applyStimulus(WHITE, 1'b0, Y_W, 1'b1);
        applyStimulus(RED,   1'b0, Y_R, 1'b1);
        applyStimulus(GREEN, 1'b0, Y_G, 1'b1);
        applyStimulus(BLUE,  1'b1, Y_B, 1'b1);
        idleInput();
        checkOutput("t1_pix_count", 32'(pix_count), 32'd4);
        checkOutput("t1_frame_count", 32'(frame_count), 32'd1);
        checkOutput("t1_len_error", {31'h0, len_error}, 32'h0);
        drainScoreboard();

        // Short packet against EXPECTED_LEN=4, then a correct one
        applyStimulus(BLUE, 1'b0, Y_B, 1'b0);
        applyStimulus(BLUE, 1'b0, Y_B, 1'b0);
        applyStimulus(BLUE, 1'b1, Y_B, 1'b0);
        idleInput();
        checkOutput("len_error_set", {31'h0, len_error}, 32'h1);
        checkOutput("len_pix_count", 32'(pix_count), 32'd3);
        checkOutput("len_frame_count", 32'(frame_count), 32'd2);
        applyStimulus(BLACK, 1'b0, ZERO, 1'b0);
        applyStimulus(BLACK, 1'b0, ZERO, 1'b0);
        applyStimulus(BLACK, 1'b0, ZERO, 1'b0);
        applyStimulus(WHITE, 1'b1, Y_W, 1'b0);
        idleInput();
        checkOutput("len_error_sticky", {31'h0, len_error}, 32'h1);
        checkOutput("len_pix_count4", 32'(pix_count), 32'd4);
        checkOutput("len_frame_count3", 32'(frame_count), 32'd3);
        drainScoreboard();

        // Binarisation: red Y=76 < 128, green Y=149 >= 128
        cfg_thresh_en = 1'b1;
        cfg_thresh    = 8'd128;
        cfg_invert    = 1'b0;
        applyStimulus(RED,   1'b0, ZERO, 1'b0);
        applyStimulus(GREEN, 1'b1, Y_W,  1'b0);
        cfg_invert = 1'b1;
        applyStimulus(RED,   1'b0, Y_W,  1'b0);
        applyStimulus(GREEN, 1'b1, ZERO, 1'b0);
        idleInput();
        checkOutput("thr_frame_count", 32'(frame_count), 32'd5);
        drainScoreboard();

        // Stall: m_ready low for 10 cycles with s_valid held high
        cfg_thresh_en = 1'b0;
        cfg_invert    = 1'b0;
        m_ready = 1'b0;
        idx = 0;
        acc = 0;
        s_valid = 1'b1;
        s_data  = stall_in[0];
        s_strb  = strb_pat;
        s_last  = 1'b0;
        stall_snap = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            took = s_ready && (idx < 4);
            if (took) begin
                mon_e.data = stall_exp[idx];
                mon_e.strb = strb_pat;
                mon_e.last = (idx == 3);
                mon_e.cyc  = cyc;
                mon_e.lat  = 1'b0;
                sb.push_back(mon_e);
                acc++;
            end
            if (c == 3) stall_snap = m_data;
            @(posedge aclk);
            #1;
            if (took) begin
                idx++;
                strb_pat = strb_pat + 4'h3;
                s_strb   = strb_pat;
                if (idx < 4) begin
                    s_data = stall_in[idx];
                    s_last = (idx == 3);
                end
            end
        end
        checkOutput("stall_accepted", 32'(acc), 32'd2);
        checkOutput("stall_s_ready", {31'h0, s_ready}, 32'h0);
        checkOutput("stall_m_valid", {31'h0, m_valid}, 32'h1);
        checkOutput("stall_hold", m_data, stall_snap);
        checkOutput("stall_data", m_data, Y_W);
        m_ready = 1'b1;
        applyStimulus(GREEN, 1'b0, Y_G, 1'b0);
        applyStimulus(BLUE,  1'b1, Y_B, 1'b0);
        idleInput();
        drainScoreboard();
        checkOutput("stall_frame_count", 32'(frame_count), 32'd6);

        // Mid-packet threshold change takes effect on the next packet only
        cfg_thresh_en = 1'b1;
        cfg_thresh    = 8'd128;
        cfg_invert    = 1'b0;
        applyStimulus(RED,   1'b0, ZERO, 1'b0);
        applyStimulus(GREEN, 1'b0, Y_W,  1'b0);
        cfg_thresh = 8'd0;
        applyStimulus(BLUE,  1'b0, ZERO, 1'b0);
        applyStimulus(WHITE, 1'b1, Y_W,  1'b0);
        applyStimulus(RED,   1'b0, Y_W,  1'b0);
        applyStimulus(GREEN, 1'b0, Y_W,  1'b0);
        applyStimulus(BLUE,  1'b0, Y_W,  1'b0);
        applyStimulus(BLACK, 1'b1, Y_W,  1'b0);
        idleInput();
        drainScoreboard();

        // Reset mid-packet while output is valid and stalled
        cfg_thresh_en = 1'b0;
        m_ready = 1'b0;
        applyStimulus(RED,   1'b0, Y_R, 1'b0);
        applyStimulus(GREEN, 1'b0, Y_G, 1'b0);
        idleInput();
        wait_n = 0;
        while (!m_valid && wait_n < 20) begin
            @(posedge aclk);
            #1;
            wait_n++;
        end
        checkOutput("pre_rst_m_valid", {31'h0, m_valid}, 32'h1);
        @(negedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        checkOutput("async_rst_m_valid", {31'h0, m_valid}, 32'h0);
        checkOutput("async_rst_m_data", m_data, 32'h0);
        checkOutput("async_rst_pix_count", 32'(pix_count), 32'h0);
        checkOutput("async_rst_frame_count", 32'(frame_count), 32'h0);
        checkOutput("async_rst_len_error", {31'h0, len_error}, 32'h0);
        sb.delete();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        m_ready = 1'b1;
        cfg_thresh_en = 1'b1;
        cfg_thresh    = 8'd100;
        cfg_invert    = 1'b1;
        applyStimulus(WHITE, 1'b1, ZERO, 1'b0);
        idleInput();
        checkOutput("post_rst_frame_count", 32'(frame_count), 32'd1);
        checkOutput("post_rst_pix_count", 32'(pix_count), 32'd1);
        checkOutput("post_rst_len_error", {31'h0, len_error}, 32'h1);
        drainScoreboard();
        repeat (3) @(posedge aclk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gray_threshold_stage.md
Name: gray_threshold_stage

Overview:
- Pixel-processing stage between the skid buffer output and the master stream interface in the image IP.
- Consumes 32-bit 0x00RRGGBB pixel beats and converts each to 8-bit luma.
- Optionally binarises the luma against a threshold, then emits 0x00YYYYYY beats with strb/last carried alongside.
- Counts beats per packet and frames, and flags packets whose length differs from the expected value.

Parameters:
DATA_WIDTH, 32, stream data width; must be 32; pixel in bits [23:0].
EXPECTED_LEN, 0, beats per packet for length check; 0 disables the check.
CNT_WIDTH, 24, width of pixel and frame counters.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid && s_ready
s_data  in  DATA_WIDTH  pixel {8'h00, R, G, B}
s_strb  in  DATA_WIDTH/8  byte strobes, passed through unchanged
s_last  in  1  last beat of packet (frame)
m_valid  out  1  output beat valid
m_ready  in  1  downstream ready
m_data  out  DATA_WIDTH  {8'h00, Y, Y, Y}
m_strb  out  DATA_WIDTH/8  delayed s_strb
m_last  out  1  delayed s_last
cfg_thresh_en  in  1  enable binarisation
cfg_thresh  in  8  threshold value
cfg_invert  in  1  invert binarised output
pix_count  out  CNT_WIDTH  beat count of last completed packet
frame_count  out  CNT_WIDTH  completed packets, wraps
len_error  out  1  sticky; set on length mismatch

Behaviour:
- Reset (async, aresetn low): all pipeline valids 0, m_valid=0, m_data=0, m_strb=0, m_last=0, pix_count=0, frame_count=0, len_error=0, sof=1, latched config=0.
- Reset mid-packet: in-flight beats are discarded. The next accepted beat is treated as start of frame.
- Pipeline: two register stages, S1 and S2 (S2 drives m_*).
  - Latency: 2 cycles from input handshake to m_valid with no stall.
  - Throughput: 1 beat/cycle.
- Advance rules:
  - adv2 = !v2 || m_ready.
  - adv1 = !v1 || adv2.
  - s_ready = adv1 (combinational from m_ready; the upstream skid buffer breaks the path).
  - No bubbles are inserted when m_ready stays high.
  - m_data, m_strb and m_last hold stable while m_valid && !m_ready.
- S1 (loads on s_valid && s_ready):
  - Registers pR=77*R, pG=150*G, pB=29*B, each 16-bit unsigned.
  - Registers strb and last.
- S2: sum = pR+pG+pB (17 bits internally; max 65280 fits 16 bits), Y = sum[15:8], range 0..255.
  - cfg_thresh_en=0: out byte = Y.
  - cfg_thresh_en=1: out byte = (Y >= thresh) ? 8'hFF : 8'h00, XOR'd with {8{invert}}.
  - m_data = {8'h00, out, out, out}.
- Config latching: cfg_thresh_en, cfg_thresh and cfg_invert are sampled into internal registers on the handshake of a beat with sof=1.
  - These values travel with that packet; mid-packet cfg changes have no effect until the next packet.
  - sof: cleared on any accepted beat, set on an accepted beat with s_last=1. A packet of length 1 latches config and re-arms sof on the same beat.
- Counters (updated on input handshake):
  - run_cnt increments per beat.
  - On a beat with s_last: pix_count = run_cnt+1, run_cnt = 0, frame_count += 1 (wraps at 2^CNT_WIDTH).
  - On that same beat, if EXPECTED_LEN != 0 and run_cnt+1 != EXPECTED_LEN, len_error = 1.
  - len_error is cleared only by reset.
  - run_cnt saturates at all-ones (no wrap).

Optional Feature:
- Macro GRAY_STATS_EN.
- Defined: adds outputs luma_min[7:0] and luma_max[7:0].
  - Running min/max of pre-threshold Y, tracked on S2 output handshakes.
  - Published and reset (running min=255, max=0) on the handshake of the m_last beat.
  - Output reset values: luma_min=8'hFF, luma_max=8'h00.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- m_ready=1, thresh_en=0, inputs 0x00FFFFFF, 0x00FF0000, 0x0000FF00, 0x000000FF, last on 4th -> m_data 0x00FFFFFF, 0x004C4C4C, 0x00959595, 0x001C1C1C, 2 cycles after each input; m_last on 4th; pix_count=4, frame_count=1.
- thresh_en=1, thresh=128, invert=0: red then green -> 0x00000000, 0x00FFFFFF. Same packet repeated with invert=1 -> 0x00FFFFFF, 0x00000000.
- m_ready=0 for 10 cycles with s_valid=1 continuously -> exactly 2 beats accepted, then s_ready=0 and m_data stable. On m_ready=1, all beats emerge in order with none lost or duplicated.
- cfg_thresh changed from 128 to 0 after beat 2 of a 4-beat packet -> all 4 beats use 128; next packet uses 0.
- EXPECTED_LEN=4: packet of 3 beats -> len_error=1, pix_count=3, frame_count increments. A following 4-beat packet leaves len_error=1.
- aresetn pulsed low mid-packet while m_valid=1 -> m_valid=0 asynchronously, counters 0. The next beat is sof and latches new config.
